pipe_stage_reg: RTL

Parametrised pipeline stage register that generalises the fixed EX/MEM latch into a reusable stage between any two processor pipeline stages. It carries a data payload, a control-bit field and a register-tag field, and adds a valid/ready handshake, stall back-pressure, synchronous flush with bubble insertion, and an optional two-entry skid buffer. Instances sit at ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_stage_reg_if.sv | 42 ++++
 rtl/pipe_slot.sv | 63 ++++++
 rtl/pipe_stage_reg.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the pipeline stage registers. Default
//               field widths and bit positions inside the control field.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 3;
  localparam int TAG_W_DEF  = 10;

  // Bit positions inside the control field
  localparam int CTRL_MEMWR    = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWR    = 2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream handshake bundle of one pipeline stage
//               register, plus flush request and occupancy count.
// Ports       : slave  - seen by the stage register
//               master - seen by the surrounding pipeline (or a bench)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [TAG_W-1:0]  in_tag;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        count;

  modport slave (
    input  in_valid, in_data, in_ctrl, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_tag, count
  );

  modport master (
    output in_valid, in_data, in_ctrl, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_tag, count
  );

endinterface : pipe_stage_reg_if
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One storage entry (valid, data, ctrl, tag). Updates on the
//               falling clock edge. clear beats load; the payload is only
//               written by a load that is not cleared, so a discarded beat
//               never reaches the payload registers.
// Ports       : clk, rst_n          - clock (falling edge), async low reset
//               load, clear         - entry controls
//               d_data/d_ctrl/d_tag - payload to load
//               valid/data/ctrl/tag - held entry
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic              clear,
  input  wire logic [DATA_W-1:0] d_data,
  input  wire logic [CTRL_W-1:0] d_ctrl,
  input  wire logic [TAG_W-1:0]  d_tag,
  output logic                   valid,
  output logic      [DATA_W-1:0] data,
  output logic      [CTRL_W-1:0] ctrl,
  output logic      [TAG_W-1:0]  tag
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic [TAG_W-1:0]  r_tag;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
      r_tag   <= '0;
    end else begin
      if (clear) begin
        r_valid <= 1'b0;
      end else if (load) begin
        r_valid <= 1'b1;
        r_data  <= d_data;
        r_ctrl  <= d_ctrl;
        r_tag   <= d_tag;
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign ctrl  = r_ctrl;
  assign tag   = r_tag;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Reusable pipeline stage register with valid/ready handshake,
//               stall back-pressure, flush with bubble insertion and an
//               optional two-entry skid buffer. State changes on the falling
//               clock edge.
// Ports       : clk   - stage clock (falling edge active)
//               rst_n - asynchronous active-low reset
//               bus   - handshake bundle (slave side): in_* upstream,
//                       out_* downstream, flush, count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int SKID   = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pipe_stage_reg_if.slave  bus
);

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_free;

  logic              w_main_load;
  logic              w_main_clear;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [TAG_W-1:0]  w_main_d_tag;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [TAG_W-1:0]  w_main_tag;

  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [TAG_W-1:0]  w_skid_tag;

  assign w_in_fire   = bus.in_valid & w_in_ready;
  assign w_out_fire  = w_main_valid & bus.out_ready;
  // Main can take a beat this edge if it is empty or is being drained.
  assign w_main_free = ~w_main_valid | bus.out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic w_skid_load;
      logic w_skid_clear;

      // Skid occupancy is a flop, so upstream never sees a combinational
      // path from out_ready.
      assign w_in_ready   = ~w_skid_valid;
      // With skid full, main refills from skid on drain; otherwise main
      // takes the input beat when it has room.
      assign w_main_load  = w_skid_valid ? w_out_fire : (w_in_fire & w_main_free);
      assign w_skid_load  = w_in_fire & (w_skid_valid ? w_out_fire : ~w_main_free);
      assign w_skid_clear = bus.flush | (w_skid_valid & w_out_fire & ~w_skid_load);

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .TAG_W  (TAG_W)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_skid_load),
        .clear  (w_skid_clear),
        .d_data (bus.in_data),
        .d_ctrl (bus.in_ctrl),
        .d_tag  (bus.in_tag),
        .valid  (w_skid_valid),
        .data   (w_skid_data),
        .ctrl   (w_skid_ctrl),
        .tag    (w_skid_tag)
      );
    end else begin : g_noskid
      assign w_in_ready   = ~w_main_valid | bus.out_ready;
      assign w_main_load  = w_in_fire;
      assign w_skid_valid = 1'b0;
      assign w_skid_data  = '0;
      assign w_skid_ctrl  = '0;
      assign w_skid_tag   = '0;
    end
  endgenerate

  // Older skid beat has priority over the input beat for the main entry.
  assign w_main_d_data = w_skid_valid ? w_skid_data : bus.in_data;
  assign w_main_d_ctrl = w_skid_valid ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_d_tag  = w_skid_valid ? w_skid_tag  : bus.in_tag;
  assign w_main_clear  = bus.flush | (w_out_fire & ~w_main_load);

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_main_load),
    .clear  (w_main_clear),
    .d_data (w_main_d_data),
    .d_ctrl (w_main_d_ctrl),
    .d_tag  (w_main_d_tag),
    .valid  (w_main_valid),
    .data   (w_main_data),
    .ctrl   (w_main_ctrl),
    .tag    (w_main_tag)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_main_valid;
  assign bus.out_data  = w_main_data;
  // Bubbles carry no control effects; data and tag keep their last value.
  assign bus.out_ctrl  = w_main_valid ? w_main_ctrl : '0;
  assign bus.out_tag   = w_main_tag;
  assign bus.count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule : pipe_stage_reg
`default_nettype wire
